// File: rtl/polar_enc_pkg.sv
// ----------------------------------------------------------------------------
// polar_enc_pkg
// Shared definitions for the polar encoder scheduler:
//   - FSM state encoding (2-bit constants)
//   - message width, requester-ID width, default watchdog limit
// The codeword length (`CODE_LEN) is owned by defines.v, not by this package.
// ----------------------------------------------------------------------------
package polar_enc_pkg;

   localparam int MSG_W           = 384;
   localparam int ID_W            = 1;
   localparam int TIMEOUT_CYC_DEF = 64;
   localparam int WD_W            = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/polar_rr_arb2.sv
// ----------------------------------------------------------------------------
// polar_rr_arb2
// Two-input round-robin grant logic (purely combinational).
// Ports:
//   req_valid [1:0] : request vector
//   last_id         : requester that won the previous grant
//   grant     [1:0] : one-hot grant (zero when nobody requests)
// On contention the requester that is not last_id wins; a lone requester
// always wins.
// ----------------------------------------------------------------------------
module polar_rr_arb2
   import polar_enc_pkg::*;
(
   input  logic [1:0]      req_valid,
   input  logic [ID_W-1:0] last_id,
   output logic [1:0]      grant
);

   always_comb begin
      grant = req_valid;
      if (req_valid == 2'b11) begin
         grant = (last_id == '0) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/polar_enc_sched.sv
// ----------------------------------------------------------------------------
// polar_enc_sched
// Round-robin scheduler / sequencer for one polar encoder. Captures a message
// from one of two requesters, pulses enc_start, holds the encoder inputs,
// waits for enc_done and presents the codeword on a valid/ready output
// tagged with the owning requester ID. One frame in flight at a time.
//
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]    : per-requester handshake (ready is one-hot,
//                                  combinational, only in IDLE)
//   req_rate_sel [1:0]           : per-requester rate (0 = 1/4, 1 = 3/8)
//   req_data0, req_data1         : requester messages
//   enc_start, enc_rate_sel,
//   enc_data_in                  : encoder controls (registered)
//   enc_done, enc_data_dout      : encoder completion and codeword
//   out_valid/out_ready,
//   out_data, out_id,
//   out_rate_sel                 : result stream (registered)
//   busy                         : state is not IDLE
//   err_timeout                  : one-cycle watchdog expiry pulse
//
// Optional feature: define POLAR_ENC_SCHED_TIMEOUT_EN to enable the WAIT
// watchdog (TIMEOUT_CYC cycles). Without it WAIT waits indefinitely and
// err_timeout is constant 0.
// ----------------------------------------------------------------------------
`ifndef CODE_LEN
`define CODE_LEN 1024
`endif

module polar_enc_sched #(
   parameter int MSG_W       = polar_enc_pkg::MSG_W,
   parameter int CODE_W      = `CODE_LEN,
   parameter int TIMEOUT_CYC = polar_enc_pkg::TIMEOUT_CYC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [1:0]        req_rate_sel,
   input  logic [MSG_W-1:0]  req_data0,
   input  logic [MSG_W-1:0]  req_data1,
   output logic              enc_start,
   output logic              enc_rate_sel,
   output logic [MSG_W-1:0]  enc_data_in,
   input  logic              enc_done,
   input  logic [CODE_W-1:0] enc_data_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_data,
   output logic              out_id,
   output logic              out_rate_sel,
   output logic              busy,
   output logic              err_timeout
);
   import polar_enc_pkg::*;

   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   last_id_q, last_id_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [MSG_W-1:0]  msg_q, msg_d;
   logic              rate_q, rate_d;
   logic [CODE_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              enc_start_q, enc_start_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic [1:0]        grant;
   logic [1:0]        hs_vec;
   logic              timeout_hit;

   polar_rr_arb2 u_arb (
      .req_valid (req_valid),
      .last_id   (last_id_q),
      .grant     (grant)
   );

   // Grants are only offered in IDLE, so a frame can never be accepted
   // while another one is in flight.
   assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
   assign hs_vec    = req_valid & req_ready;

`ifdef POLAR_ENC_SCHED_TIMEOUT_EN
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC);

   logic [WD_W-1:0] wd_q, wd_d;

   // Counts WAIT cycles without enc_done; hit on the TIMEOUT_CYC-th one so
   // the pulse and the return to IDLE land TIMEOUT_CYC cycles into WAIT.
   always_comb begin
      wd_d        = wd_q;
      timeout_hit = 1'b0;
      if (state_q == ST_ISSUE) begin
         wd_d = '0;
      end else if ((state_q == ST_WAIT) && !enc_done) begin
         wd_d        = wd_q + 1'b1;
         timeout_hit = (wd_d == WD_LIMIT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   // No watchdog: the comparison is constant false for any legal limit.
   assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

   always_comb begin
      state_d     = state_q;
      last_id_d   = last_id_q;
      id_d        = id_q;
      msg_d       = msg_q;
      rate_d      = rate_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      enc_start_d = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|hs_vec) begin
               // hs_vec is one-hot, so bit 1 is the winning requester ID.
               id_d        = ID_W'(hs_vec[1]);
               last_id_d   = ID_W'(hs_vec[1]);
               msg_d       = hs_vec[1] ? req_data1 : req_data0;
               rate_d      = req_rate_sel[hs_vec[1]];
               enc_start_d = 1'b1;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done in the same cycle as the watchdog limit still wins.
            if (enc_done) begin
               out_data_d  = enc_data_dout;
               out_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin // ST_HOLD
            out_valid_d = 1'b1;
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         last_id_q   <= '1;
         id_q        <= '0;
         msg_q       <= '0;
         rate_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         enc_start_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_id_q   <= last_id_d;
         id_q        <= id_d;
         msg_q       <= msg_d;
         rate_q      <= rate_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         enc_start_q <= enc_start_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign enc_start    = enc_start_q;
   assign enc_rate_sel = rate_q;
   assign enc_data_in  = msg_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_id       = id_q[0];
   assign out_rate_sel = rate_q;
   assign busy         = busy_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_polar_enc_sched.sv
// ----------------------------------------------------------------------------
// tb_polar_enc_sched
// Scoreboard bench for polar_enc_sched: every accepted request pushes its
// expected owner/rate/message; results are compared against the queue head
// while out_valid is high and popped on the output handshake. A behavioural
// encoder returns a message-derived codeword after a programmable latency.
// ----------------------------------------------------------------------------
`ifndef CODE_LEN
`define CODE_LEN 1024
`endif

module tb_polar_enc_sched;
   import polar_enc_pkg::*;

   localparam int CW  = `CODE_LEN;
   localparam int MW  = MSG_W;
   localparam int TMO = 20;

   typedef struct packed {
      logic          id;
      logic          rate;
      logic [MW-1:0] msg;
   } exp_t;

   logic          clk, rst_n;
   logic [1:0]    req_valid, req_ready, req_rate_sel;
   logic [MW-1:0] req_data0, req_data1, enc_data_in;
   logic          enc_start, enc_rate_sel, enc_done;
   logic [CW-1:0] enc_data_dout, out_data;
   logic          out_valid, out_ready, out_id, out_rate_sel, busy, err_timeout;

   polar_enc_sched #(.MSG_W(MW), .CODE_W(CW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rate_sel(req_rate_sel),
      .req_data0(req_data0), .req_data1(req_data1),
      .enc_start(enc_start), .enc_rate_sel(enc_rate_sel), .enc_data_in(enc_data_in),
      .enc_done(enc_done), .enc_data_dout(enc_data_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_id(out_id), .out_rate_sel(out_rate_sel),
      .busy(busy), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (low 64 bits)", tag, got[63:0], exp[63:0]);
      end
   endtask

   function automatic logic [CW-1:0] code_of(input logic [MW-1:0] m, input logic r);
      logic [CW-1:0] c;
      for (int i = 0; i < CW; i++) c[i] = m[i % MW] ^ (r & i[0]) ^ (i[2] & i[1]);
      return c;
   endfunction

   function automatic logic [MW-1:0] rand_msg();
      logic [MW-1:0] m;
      m = '0;
      for (int i = 0; i < (MW + 31) / 32; i++) m = (m << 32) | MW'($urandom);
      return m;
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural encoder ----------------
   int            enc_lat = 6;   // 0 = never answers
   int            enc_cnt = 0;
   logic          spur_done = 1'b0;
   logic [MW-1:0] cap_msg;
   logic          cap_rate;

   initial begin
      enc_done      = 1'b0;
      enc_data_dout = '0;
      forever begin
         @(posedge clk);
         #2;
         enc_done = 1'b0;
         for (int i = 0; i < CW; i++) enc_data_dout[i] = 1'($urandom_range(1, 0));
         if (!rst_n) begin
            enc_cnt = 0;
         end else begin
            if (spur_done) enc_done = 1'b1;
            if (enc_cnt > 0) begin
               enc_cnt--;
               if (enc_cnt == 0) begin
                  enc_done      = 1'b1;
                  enc_data_dout = code_of(cap_msg, cap_rate);
               end
            end
            if (enc_start && enc_lat > 0) begin
               cap_msg  = enc_data_in;
               cap_rate = enc_rate_sel;
               enc_cnt  = enc_lat;
            end
         end
      end
   end

   // ---------------- reference model + scoreboard ----------------
   exp_t          sb[$];
   int            grant_log[$];
   logic [1:0]    m_state = ST_IDLE;
   logic          m_last  = 1'b1;
   logic          m_err   = 1'b0;
   int            m_cnt   = 0;
   int            hs_cyc = 0, start_cyc = 0, ov_cyc = 0, err_cyc = 0, out_hs_cyc = 0;
   int            out_cnt = 0;
   logic          prev_ov = 1'b0;
   logic [CW-1:0] last_data;
   logic          last_id, last_rate;

   always @(negedge clk) begin
      logic [1:0] exp_rdy;
      exp_t       e;
      if (!rst_n) begin
         check("rst_busy", CW'(busy), '0);
         check("rst_out_valid", CW'(out_valid), '0);
         check("rst_enc_start", CW'(enc_start), '0);
         check("rst_err", CW'(err_timeout), '0);
         m_state = ST_IDLE; m_last = 1'b1; m_err = 1'b0; m_cnt = 0;
         sb.delete(); prev_ov = 1'b0;
      end else begin
         exp_rdy = 2'b00;
         if (m_state == ST_IDLE)
            exp_rdy = (req_valid == 2'b11) ? (m_last ? 2'b01 : 2'b10) : req_valid;
         check("req_ready", CW'(req_ready), CW'(exp_rdy));
         check("enc_start", CW'(enc_start), CW'(m_state == ST_ISSUE));
         check("busy", CW'(busy), CW'(m_state != ST_IDLE));
         check("out_valid", CW'(out_valid), CW'(m_state == ST_HOLD));
         check("err_timeout", CW'(err_timeout), CW'(m_err));
         if (m_state == ST_WAIT && sb.size() > 0) begin
            check("enc_data_in", CW'(enc_data_in), CW'(sb[0].msg));
            check("enc_rate_sel", CW'(enc_rate_sel), CW'(sb[0].rate));
         end
         if (out_valid && sb.size() > 0) begin
            check("out_data", out_data, code_of(sb[0].msg, sb[0].rate));
            check("out_id", CW'(out_id), CW'(sb[0].id));
            check("out_rate_sel", CW'(out_rate_sel), CW'(sb[0].rate));
         end
         if (out_valid && !prev_ov) ov_cyc = cyc;
         if (enc_start) start_cyc = cyc;
         if (err_timeout) err_cyc = cyc;
         prev_ov = out_valid;

         m_err = 1'b0;
         case (m_state)
            ST_IDLE: begin
               if (|(req_valid & exp_rdy)) begin
                  e.id   = exp_rdy[1];
                  e.rate = req_rate_sel[exp_rdy[1]];
                  e.msg  = exp_rdy[1] ? req_data1 : req_data0;
                  sb.push_back(e);
                  grant_log.push_back(int'(exp_rdy[1]));
                  m_last  = exp_rdy[1];
                  hs_cyc  = cyc;
                  m_state = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               m_state = ST_WAIT;
               m_cnt   = 0;
            end
            ST_WAIT: begin
               if (enc_done) begin
                  m_state = ST_HOLD;
               end else begin
`ifdef POLAR_ENC_SCHED_TIMEOUT_EN
                  m_cnt++;
                  if (m_cnt == TMO) begin
                     m_state = ST_IDLE;
                     m_err   = 1'b1;
                     void'(sb.pop_front());
                  end
`endif
               end
            end
            default: begin
               if (out_ready) begin
                  e = sb.pop_front();
                  last_data  = out_data;
                  last_id    = out_id;
                  last_rate  = out_rate_sel;
                  out_hs_cyc = cyc;
                  out_cnt++;
                  m_state = ST_IDLE;
               end
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int id, input logic rate, input logic [MW-1:0] d);
      logic ok;
      ok = 1'b0;
      if (id == 0) begin req_data0 = d; req_rate_sel[0] = rate; end
      else         begin req_data1 = d; req_rate_sel[1] = rate; end
      req_valid[id] = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (req_ready[id]) begin ok = 1'b1; break; end
      end
      check("grant_wait", CW'(ok), CW'(1));
      tick();
      req_valid[id] = 1'b0;
   endtask

   task automatic wait_idle();
      int lim;
      lim = 0;
      while ((busy || sb.size() != 0) && lim < 500) begin tick(); lim++; end
      check("idle_wait", CW'(lim < 500), CW'(1));
   endtask

   task automatic wait_grant();
      int g0, lim;
      g0 = grant_log.size(); lim = 0;
      while (grant_log.size() == g0 && lim < 300) begin tick(); lim++; end
      check("grant_seen", CW'(grant_log.size() > g0), CW'(1));
   endtask

   initial begin
      int base, g0, lim;
      rst_n = 1'b0; req_valid = 2'b00; req_rate_sel = 2'b00;
      req_data0 = '0; req_data1 = '0; out_ready = 1'b1;

      // Reset state
      tick();
      check("rst_enc_data_in", CW'(enc_data_in), '0);
      check("rst_out_data", out_data, '0);
      check("rst_enc_rate", CW'(enc_rate_sel), '0);
      check("rst_out_id", CW'(out_id), '0);
      check("rst_out_rate", CW'(out_rate_sel), '0);
      req_valid = 2'b11;
      #1;
      check("rst_req_ready", CW'(req_ready), CW'(2'b01));
      req_valid = 2'b00;
      tick(); rst_n = 1'b1; tick();
      $display("reset: done");

      // Contention after reset: both valid for four frames
      base = out_cnt; g0 = grant_log.size();
      req_valid = 2'b11; lim = 0;
      while (out_cnt < base + 4 && lim < 400) begin
         req_data0 = rand_msg(); req_data1 = rand_msg();
         req_rate_sel = 2'($urandom_range(3, 0));
         tick(); lim++;
      end
      req_valid = 2'b00;
      wait_idle();
      check("contend_frames", CW'(grant_log.size() >= g0 + 4), CW'(1));
      for (int i = 0; i < 4; i++)
         if (g0 + i < grant_log.size())
            check("contend_order", CW'(grant_log[g0 + i]), CW'(i % 2));
      $display("contention: grants=%0d", grant_log.size() - g0);

      // Single request, rate 0, message 1, encoder done 6 cycles after start
      enc_lat = 6;
      send(0, 1'b0, MW'(1));
      wait_idle();
      check("single_start_lat", CW'(start_cyc - hs_cyc), CW'(1));
      check("single_valid_lat", CW'(ov_cyc - start_cyc), CW'(7));
      check("single_id", CW'(last_id), '0);
      check("single_rate", CW'(last_rate), '0);
      check("single_data", last_data, code_of(MW'(1), 1'b0));
      $display("single: start+%0d out_valid+%0d", start_cyc - hs_cyc, ov_cyc - start_cyc);

      // Back-pressure: requester 1 frame held 10 cycles with both requesters waiting
      out_ready = 1'b0;
      send(1, 1'b1, rand_msg());
      lim = 0;
      while (!out_valid && lim < 100) begin tick(); lim++; end
      check("bp_valid_seen", CW'(out_valid), CW'(1));
      req_data0 = rand_msg(); req_data1 = rand_msg(); req_valid = 2'b11;
      g0 = grant_log.size();
      for (int i = 0; i < 10; i++) tick();
      check("bp_no_grant", CW'(grant_log.size()), CW'(g0));
      check("bp_out_id", CW'(out_id), CW'(1));
      out_ready = 1'b1;
      wait_grant();
      req_valid = 2'b00;
      check("bp_next_grant", CW'(grant_log[grant_log.size() - 1]), CW'(0));
      check("bp_grant_after_out", CW'(hs_cyc - out_hs_cyc), CW'(1));
      wait_idle();
      $display("backpressure: next grant=%0d", grant_log[grant_log.size() - 1]);

      // Spurious done in IDLE
      base = out_cnt;
      spur_done = 1'b1; tick(); spur_done = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check("spur_busy", CW'(busy), '0);
      check("spur_out_valid", CW'(out_valid), '0);
      check("spur_no_output", CW'(out_cnt), CW'(base));
      $display("spurious done: outputs=%0d", out_cnt - base);

`ifdef POLAR_ENC_SCHED_TIMEOUT_EN
      // Watchdog: encoder never answers
      enc_lat = 0;
      base = out_cnt;
      send(0, 1'b0, rand_msg());
      lim = 0;
      while (!err_timeout && lim < 100) begin tick(); lim++; end
      check("tmo_seen", CW'(err_timeout), CW'(1));
      check("tmo_delay", CW'(err_cyc - start_cyc), CW'(TMO + 1));
      check("tmo_busy", CW'(busy), '0);
      enc_lat = 6;
      req_data0 = rand_msg(); req_data1 = rand_msg(); req_valid = 2'b11;
      wait_grant();
      req_valid = 2'b00;
      check("tmo_next_grant", CW'(grant_log[grant_log.size() - 1]), CW'(1));
      wait_idle();
      check("tmo_outputs", CW'(out_cnt), CW'(base + 1));
      $display("timeout: err after %0d cycles", err_cyc - start_cyc);
`endif

      // Reset mid-frame (in WAIT)
      enc_lat = 6;
      send(1, 1'b1, rand_msg());
      tick(); tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_busy", CW'(busy), '0);
      check("mid_out_valid", CW'(out_valid), '0);
      check("mid_enc_start", CW'(enc_start), '0);
      check("mid_enc_data_in", CW'(enc_data_in), '0);
      check("mid_out_data", out_data, '0);
      check("mid_rates", CW'({enc_rate_sel, out_rate_sel, out_id}), '0);
      tick(); tick(); rst_n = 1'b1; tick();
      req_data0 = rand_msg(); req_data1 = rand_msg(); req_valid = 2'b11;
      wait_grant();
      req_valid = 2'b00;
      check("mid_first_grant", CW'(grant_log[grant_log.size() - 1]), CW'(0));
      wait_idle();
      $display("reset mid-frame: first grant=%0d", grant_log[grant_log.size() - 1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit");
   end

endmodule

// File: doc/polar_enc_sched.md
# polar_enc_sched

Two-requester round-robin scheduler and sequencer for the polar encoder (`POLAR_ENC`). It captures one 384-bit message at a time from either requester and drives the encoder's single-cycle start pulse. It holds the encoder inputs stable, waits for `polar_enc_done`, and returns the codeword to a shared valid/ready output tagged with the requester ID. Only one frame is in flight at a time, and an optional watchdog recovers from a missing done.

## Interface
Parameters:
- `MSG_W`, 384: message width; must match the encoder's `polar_enc_data_in`.
- `CODE_W`, `` `CODE_LEN ``: codeword width.
- `TIMEOUT_CYC`, 64: watchdog limit in cycles spent in WAIT. Used only with the timeout macro.

Ports:
- `clk`, in, 1: 64 MHz clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `req_valid`, in, 2: per-requester frame valid.
- `req_ready`, out, 2: per-requester accept; at most one bit high.
- `req_rate_sel`, in, 2: per-requester rate; 0 = 1/4, 1 = 3/8.
- `req_data0`, in, MSG_W: requester 0 message.
- `req_data1`, in, MSG_W: requester 1 message.
- `enc_start`, out, 1: one-cycle start pulse to the encoder.
- `enc_rate_sel`, out, 1: rate select to the encoder.
- `enc_data_in`, out, MSG_W: message to the encoder.
- `enc_done`, in, 1: encoder done.
- `enc_data_dout`, in, CODE_W: encoder codeword.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: downstream accept.
- `out_data`, out, CODE_W: codeword.
- `out_id`, out, 1: ID of the requester that owns the result.
- `out_rate_sel`, out, 1: rate used for this frame.
- `busy`, out, 1: high in any state other than IDLE.
- `err_timeout`, out, 1: one-cycle pulse on watchdog expiry.

## Operation
- States: IDLE, ISSUE, WAIT, HOLD.
- **IDLE**
  - `req_ready` is the one-hot grant. It is combinational from `req_valid` and `last_id`.
  - When both requesters are valid, grant the requester that is not `last_id`. When only one is valid, grant it.
  - On handshake (`req_valid[i] & req_ready[i]`): register the message, rate and ID, set `last_id` = i, and go to ISSUE.
- **ISSUE**
  - `enc_start` = 1 for exactly this cycle.
  - Clear the watchdog counter.
  - Go to WAIT.
- **WAIT**
  - `enc_data_in` and `enc_rate_sel` are held at the captured values.
  - On `enc_done`: register `enc_data_dout` into `out_data` and go to HOLD.
  - `enc_done` seen in any state other than WAIT is ignored.
- **HOLD**
  - `out_valid` = 1.
  - `out_data`, `out_id` and `out_rate_sel` are stable until `out_ready`.
  - On `out_ready`: go to IDLE.
  - No new request is accepted before the following cycle.
- `req_ready` is 0 in every state other than IDLE, so no frame is dropped.
- A requester may drop `req_valid` before being granted; no state is kept for an ungranted request.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready` reflects IDLE arbitration.
  - `enc_start`, `out_valid`, `busy` and `err_timeout` = 0.
  - `enc_data_in`, `out_data`, `enc_rate_sel`, `out_id` and `out_rate_sel` = 0.
  - `last_id` = 1, so requester 0 wins the first contention.
- Latency:
  - Handshake in cycle t.
  - `enc_start` high in t+1.
  - Encoder done in cycle d (d > t+1).
  - `out_valid` high from d+1.
  - Minimum handshake-to-handshake spacing is (d − t) + 2 cycles with `out_ready` tied high.
- Reset mid-frame: everything returns immediately to reset values and any in-flight result is discarded.
- All outputs are registered except `req_ready`.

## Configuration
- Macro: `POLAR_ENC_SCHED_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter runs in WAIT.
  - When it reaches `TIMEOUT_CYC` without `enc_done`, `err_timeout` pulses for one cycle and the state returns to IDLE.
  - No `out_valid` is produced for that frame.
  - `last_id` keeps the failed requester, so the other requester gets priority next.
- Undefined:
  - No counter; WAIT waits indefinitely.
  - `err_timeout` is tied to 0.

## Structure
- Shared package `polar_enc_pkg` holds:
  - The state encoding (2-bit localparams).
  - `MSG_W`.
  - The requester-ID width.
  - The default `TIMEOUT_CYC`.
  - `` `CODE_LEN `` stays in `defines.v`.
- One sub-module, `polar_rr_arb2`: two-input round-robin grant logic taking `req_valid` and `last_id`, returning a one-hot grant.
- FSM, capture registers and watchdog stay in the top module.

## Test plan
- **Single request:** requester 0 only, rate 0, `req_data0` = 384'h1, encoder model done 6 cycles after start.
  - `enc_start` exactly one cycle, the cycle after the handshake.
  - `out_valid` 7 cycles after start.
  - `out_id` = 0, `out_rate_sel` = 0, `out_data` equals the model codeword.
- **Contention after reset:** both requesters valid.
  - Grant order 0, 1, 0, 1 over four frames.
  - `req_ready` never has both bits high.
- **Back-pressure:** `out_ready` low for 10 cycles in HOLD.
  - `out_data` and `out_id` stable.
  - `req_ready` = 0 throughout.
  - A new grant is possible only after the `out_ready` handshake.
- **Spurious done:** `enc_done` pulsed while in IDLE.
  - No `out_valid`.
  - State stays IDLE.
- **Timeout (macro on, `TIMEOUT_CYC` = 20):** no `enc_done` after start.
  - `err_timeout` pulses 20 cycles into WAIT.
  - `busy` drops and no `out_valid` is produced.
  - The next contention grants the other requester.
- **Reset mid-frame:** `rst_n` asserted in WAIT.
  - All outputs return to reset values asynchronously.
  - The first post-reset contention grants requester 0.
